// File: rtl/perf_traffic_gen_pkg.sv
// Shared constants for the synthetic AXI-stream traffic generator:
// class count, window size, header field layout and FSM encoding.
package perf_traffic_gen_pkg;
  localparam int NUM_CLASS   = 5;
  localparam int WINDOW_BITS = 10;
  localparam int BEAT_W      = 12;
  localparam int LEN_OF      = 0;
  localparam int LEN_SIZE    = 16;
  localparam int CLASS_OF    = 16;
  localparam int CLASS_SIZE  = 5;
  localparam int SEQ_OF      = 32;
  localparam int SEQ_SIZE    = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    SEND   = 2'd2
  } state_t;
endpackage

// File: rtl/perf_traffic_gen_arb.sv
// 5-way round-robin picker: search starts at the class after ptr and the
// first eligible class wins; ptr_nxt is the pointer value to commit on grant.
module rr_class_arbiter
  import perf_traffic_gen_pkg::*;
(
  input  logic [NUM_CLASS-1:0] elig,
  input  logic [2:0]           ptr,
  output logic [2:0]           gnt_idx,
  output logic                 gnt_vld,
  output logic [2:0]           ptr_nxt
);
  logic [2:0] idx;

  // Walk from farthest to nearest so the nearest eligible class is written last.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int off = NUM_CLASS; off >= 1; off--) begin
      idx = 3'((int'(ptr) + off) % NUM_CLASS);
      if (elig[idx]) begin
        gnt_idx = idx;
        gnt_vld = 1'b1;
      end
    end
    ptr_nxt = gnt_vld ? gnt_idx : ptr;
  end
endmodule

// File: rtl/perf_traffic_gen.sv
// Round-robin packet source over five flow classes with per-window frame
// budgets; beat 0 of every packet is a self-describing header.
module perf_traffic_gen
  import perf_traffic_gen_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 256,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_enable,
  input  logic [NUM_CLASS-1:0]       cfg_class_mask,
  input  logic [15:0]                cfg_pk_len,
  input  logic [NUM_CLASS*16-1:0]    cfg_budget,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [4:0]                 m_flow_class,
  output logic [15:0]                m_pk_len,
  output logic [31:0]                sent_pk_count,
  output logic [47:0]                sent_frame_count
);
  localparam int KW_LOG = $clog2(AXIS_KEEP_WIDTH);

  state_t                         state;
  logic [NUM_CLASS-1:0][15:0]     budget;
  logic [NUM_CLASS-1:0][15:0]     used;
  logic [NUM_CLASS-1:0][31:0]     seq;
  logic [WINDOW_BITS-1:0]         win;
  logic [2:0]                     ptr, gnt_idx, ptr_nxt;
  logic                           gnt_vld;
  logic [NUM_CLASS-1:0]           elig;
  logic [BEAT_W-1:0]              beats, pk_beats, beat_idx, beat_nxt;

  assign budget   = cfg_budget;
  assign beats    = BEAT_W'(cfg_pk_len >> KW_LOG) + BEAT_W'(|cfg_pk_len[KW_LOG-1:0]);
  assign beat_nxt = beat_idx + 1'b1;

  for (genvar i = 0; i < NUM_CLASS; i++) begin : g_elig
    assign elig[i] = cfg_class_mask[i] && (cfg_pk_len != '0) &&
                     ((budget[i] == '0) ||
                      ({1'b0, used[i]} + 17'(beats) <= {1'b0, budget[i]}));
  end

  rr_class_arbiter u_arb (
    .elig    (elig),
    .ptr     (ptr),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .ptr_nxt (ptr_nxt)
  );

  function automatic logic [AXIS_KEEP_WIDTH-1:0] keep_for(input logic [15:0] len);
    logic [KW_LOG-1:0]          rem;
    logic [AXIS_KEEP_WIDTH-1:0] k;
    rem = len[KW_LOG-1:0];
    k   = '1;
    if (rem != '0)
      for (int b = 0; b < AXIS_KEEP_WIDTH; b++) k[b] = (b < int'(rem));
    return k;
  endfunction

  function automatic logic [AXIS_DATA_WIDTH-1:0] header(input logic [15:0] len,
                                                        input logic [2:0]  cls,
                                                        input logic [31:0] sq);
    logic [AXIS_DATA_WIDTH-1:0] d;
    d = '0;
    d[LEN_OF +: LEN_SIZE]     = len;
    d[CLASS_OF +: CLASS_SIZE] = {2'b00, cls};
    d[SEQ_OF +: SEQ_SIZE]     = sq;
    return d;
  endfunction

  function automatic logic [AXIS_DATA_WIDTH-1:0] payload(input logic [BEAT_W-1:0] k);
    return {(AXIS_DATA_WIDTH/16){{4'b0000, k}}};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      used             <= '0;
      seq              <= '0;
      win              <= '0;
      ptr              <= 3'd4;
      pk_beats         <= '0;
      beat_idx         <= '0;
      m_axis_tdata     <= '0;
      m_axis_tkeep     <= '0;
      m_axis_tvalid    <= 1'b0;
      m_axis_tlast     <= 1'b0;
      m_flow_class     <= '0;
      m_pk_len         <= '0;
      sent_pk_count    <= '0;
      sent_frame_count <= '0;
    end else begin
      win <= win + 1'b1;
      if (win == '0) used <= '0;
      if (m_axis_tvalid && m_axis_tready) begin
        sent_frame_count <= sent_frame_count + 1'b1;
        if (m_axis_tlast) sent_pk_count <= sent_pk_count + 1'b1;
      end
      case (state)
        IDLE: if (cfg_enable) state <= SELECT;
        SELECT: begin
          if (!cfg_enable) begin
            state <= IDLE;
          end else if (gnt_vld) begin
            state         <= SEND;
            ptr           <= ptr_nxt;
            m_pk_len      <= cfg_pk_len;
            m_flow_class  <= {2'b00, gnt_idx};
            // A charge in the clearing cycle restarts the class from this packet.
            used[gnt_idx] <= (win == '0) ? 16'(beats) : used[gnt_idx] + 16'(beats);
            seq[gnt_idx]  <= seq[gnt_idx] + 32'd1;
            pk_beats      <= beats;
            beat_idx      <= '0;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= header(cfg_pk_len, gnt_idx, seq[gnt_idx]);
            m_axis_tlast  <= (beats == BEAT_W'(1));
            m_axis_tkeep  <= (beats == BEAT_W'(1)) ? keep_for(cfg_pk_len) : '1;
          end
        end
        SEND: begin
          if (m_axis_tready) begin
            if (m_axis_tlast) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              state         <= SELECT;
            end else begin
              beat_idx     <= beat_nxt;
              m_axis_tdata <= payload(beat_nxt);
              m_axis_tlast <= (beat_nxt == pk_beats - 1'b1);
              m_axis_tkeep <= (beat_nxt == pk_beats - 1'b1) ? keep_for(m_pk_len) : '1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_perf_traffic_gen.sv
// Directed bench for perf_traffic_gen: packet-format table, back-to-back
// round robin, window budgets, random backpressure and mid-packet reset.
module tb_perf_traffic_gen;
  localparam int DW = 256;
  localparam int KW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_enable = 1'b0;
  logic [4:0]    cfg_class_mask = '0;
  logic [15:0]   cfg_pk_len = '0;
  logic [79:0]   cfg_budget = '0;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic [4:0]    m_flow_class;
  logic [15:0]   m_pk_len;
  logic [31:0]   sent_pk_count;
  logic [47:0]   sent_frame_count;

  int checks = 0;
  int failures = 0;
  int acc_beats = 0;

  perf_traffic_gen #(.AXIS_DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_enable       (cfg_enable),
    .cfg_class_mask   (cfg_class_mask),
    .cfg_pk_len       (cfg_pk_len),
    .cfg_budget       (cfg_budget),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .m_flow_class     (m_flow_class),
    .m_pk_len         (m_pk_len),
    .sent_pk_count    (sent_pk_count),
    .sent_frame_count (sent_frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  mask;
    logic [15:0] len;
    int          exp_cls;
    int          exp_seq;
    int          exp_beats;
    logic [31:0] exp_keep;
  } vec_t;

  typedef struct {
    int          cls;
    int          seq;
    int          len;
    int          beats;
    logic [4:0]  mfc;
    logic [15:0] mpl;
    logic [31:0] last_keep;
    bit          data_ok;
    bit          keep_ok;
    bit          hdr_ok;
    bit          stable_ok;
    bit          timeout;
  } pkt_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rep(input int k);
    logic [DW-1:0] r;
    for (int l = 0; l < DW/16; l++) r[l*16 +: 16] = 16'(k);
    return r;
  endfunction

  task automatic do_reset();
    cfg_enable = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Collects one packet; with rnd set, tready toggles randomly and every
  // stalled beat must be presented unchanged on the next cycle.
  task automatic get_pkt(input bit rnd, output pkt_t p);
    int k = 0;
    int guard = 0;
    bit done = 0;
    bit stalled = 0;
    logic [DW-1:0] sd = '0;
    logic [KW-1:0] sk = '0;
    logic sl = 1'b0;
    logic [4:0] sc = '0;
    logic [15:0] sp = '0;
    p = '{default: 0};
    p.data_ok = 1; p.keep_ok = 1; p.hdr_ok = 1; p.stable_ok = 1;
    while (!done && guard < 5000) begin
      guard++;
      if (m_axis_tvalid) begin
        if (stalled && (m_axis_tdata !== sd || m_axis_tkeep !== sk || m_axis_tlast !== sl ||
                        m_flow_class !== sc || m_pk_len !== sp))
          p.stable_ok = 0;
        m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (m_axis_tready) begin
          acc_beats++;
          if (k == 0) begin
            p.cls = int'(m_axis_tdata[20:16]);
            p.seq = int'(m_axis_tdata[63:32]);
            p.len = int'(m_axis_tdata[15:0]);
            p.mfc = m_flow_class;
            p.mpl = m_pk_len;
            if (m_axis_tdata[31:21] != '0 || m_axis_tdata[DW-1:64] != '0) p.hdr_ok = 0;
          end else if (m_axis_tdata !== rep(k)) begin
            p.data_ok = 0;
          end
          if (m_axis_tlast) begin
            p.last_keep = m_axis_tkeep;
            p.beats = k + 1;
            done = 1;
          end else if (m_axis_tkeep !== '1) begin
            p.keep_ok = 0;
          end
          k++;
          stalled = 0;
        end else begin
          stalled = 1;
          sd = m_axis_tdata; sk = m_axis_tkeep; sl = m_axis_tlast;
          sc = m_flow_class; sp = m_pk_len;
        end
      end
      tick();
    end
    p.timeout = !done;
    m_axis_tready = 1'b1;
  endtask

  vec_t vecs[9];
  pkt_t p;
  int lat, seen, ev, ph, pn;

  initial begin
    vecs[0] = '{5'b00001, 16'd64, 0, 0, 2, 32'hFFFF_FFFF};
    vecs[1] = '{5'b00001, 16'd64, 0, 1, 2, 32'hFFFF_FFFF};
    vecs[2] = '{5'b00001, 16'd70, 0, 2, 3, 32'h0000_003F};
    vecs[3] = '{5'b00101, 16'd32, 2, 0, 1, 32'hFFFF_FFFF};
    vecs[4] = '{5'b00101, 16'd1,  0, 3, 1, 32'h0000_0001};
    vecs[5] = '{5'b00101, 16'd33, 2, 1, 2, 32'h0000_0001};
    vecs[6] = '{5'b11111, 16'd31, 3, 0, 1, 32'h7FFF_FFFF};
    vecs[7] = '{5'b10000, 16'd96, 4, 0, 3, 32'hFFFF_FFFF};
    vecs[8] = '{5'b11111, 16'd5,  0, 4, 1, 32'h0000_001F};

    // Reset state
    tick(); tick(); tick();
    chk("rst_tvalid", 64'(m_axis_tvalid), 0);
    chk("rst_tdata", 64'(|m_axis_tdata), 0);
    chk("rst_tkeep", 64'(m_axis_tkeep), 0);
    chk("rst_tlast", 64'(m_axis_tlast), 0);
    chk("rst_class", 64'(m_flow_class), 0);
    chk("rst_pklen", 64'(m_pk_len), 0);
    chk("rst_pkcnt", 64'(sent_pk_count), 0);
    chk("rst_frcnt", 64'(sent_frame_count), 0);
    rst_n = 1'b1;

    // Packet format table, one packet per vector, started from IDLE
    for (int i = 0; i < 9; i++) begin
      cfg_class_mask = vecs[i].mask;
      cfg_pk_len = vecs[i].len;
      cfg_enable = 1'b1;
      lat = 0;
      while (!m_axis_tvalid && lat < 20) begin tick(); lat++; end
      chk($sformatf("v%0d_latency", i), 64'(lat), 2);
      cfg_enable = 1'b0;
      get_pkt(0, p);
      chk($sformatf("v%0d_timeout", i), 64'(p.timeout), 0);
      chk($sformatf("v%0d_hdr_class", i), 64'(p.cls), 64'(vecs[i].exp_cls));
      chk($sformatf("v%0d_flow_class", i), 64'(p.mfc), 64'(vecs[i].exp_cls));
      chk($sformatf("v%0d_seq", i), 64'(p.seq), 64'(vecs[i].exp_seq));
      chk($sformatf("v%0d_hdr_len", i), 64'(p.len), 64'(vecs[i].len));
      chk($sformatf("v%0d_m_pk_len", i), 64'(p.mpl), 64'(vecs[i].len));
      chk($sformatf("v%0d_beats", i), 64'(p.beats), 64'(vecs[i].exp_beats));
      chk($sformatf("v%0d_last_keep", i), 64'(p.last_keep), 64'(vecs[i].exp_keep));
      chk($sformatf("v%0d_payload", i), 64'(p.data_ok), 1);
      chk($sformatf("v%0d_mid_keep", i), 64'(p.keep_ok), 1);
      chk($sformatf("v%0d_hdr_zero", i), 64'(p.hdr_ok), 1);
      tick(); tick();
    end

    // Zero length issues nothing
    cfg_class_mask = 5'b11111;
    cfg_pk_len = 16'd0;
    cfg_enable = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin tick(); if (m_axis_tvalid) seen++; end
    chk("len0_no_valid", 64'(seen), 0);
    cfg_enable = 1'b0;
    tick(); tick();

    // Back-to-back: classes 0,2,0,2 with one bubble between packets
    do_reset();
    cfg_class_mask = 5'b00101;
    cfg_pk_len = 16'd64;
    cfg_enable = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      ph = (i - 2) % 3;
      ev = (i >= 2 && ph != 2) ? 1 : 0;
      chk($sformatf("b2b_valid_c%0d", i), 64'(m_axis_tvalid), 64'(ev));
      if (ev == 1) begin
        chk($sformatf("b2b_last_c%0d", i), 64'(m_axis_tlast), 64'(ph == 1));
        chk($sformatf("b2b_keep_c%0d", i), 64'(m_axis_tkeep), 64'hFFFF_FFFF);
        if (ph == 0) begin
          pn = (i - 2) / 3;
          chk($sformatf("b2b_class_p%0d", pn), 64'(m_flow_class), (pn % 2 == 1) ? 64'd2 : 64'd0);
          chk($sformatf("b2b_seq_p%0d", pn), 64'(m_axis_tdata[63:32]), 64'(pn / 2));
        end
      end
    end
    cfg_enable = 1'b0;
    tick(); tick();

    // Budget: class 0 limited to 4 beats per window, 2-beat packets
    do_reset();
    cfg_budget = 80'd4;
    cfg_class_mask = 5'b00001;
    cfg_pk_len = 16'd64;
    cfg_enable = 1'b1;
    repeat (900) tick();
    chk("bud_w0_frames", 64'(sent_frame_count), 4);
    chk("bud_w0_pkts", 64'(sent_pk_count), 2);
    repeat (200) tick();
    chk("bud_w1_frames", 64'(sent_frame_count), 8);
    chk("bud_w1_pkts", 64'(sent_pk_count), 4);
    repeat (900) tick();
    chk("bud_w1_end_frames", 64'(sent_frame_count), 8);
    repeat (100) tick();
    chk("bud_w2_frames", 64'(sent_frame_count), 12);
    cfg_enable = 1'b0;
    cfg_budget = '0;
    tick(); tick();

    // Random backpressure, 3-beat packets
    do_reset();
    cfg_class_mask = 5'b00001;
    cfg_pk_len = 16'd70;
    cfg_enable = 1'b1;
    acc_beats = 0;
    for (int n = 0; n < 10; n++) begin
      get_pkt(1, p);
      chk($sformatf("rnd_p%0d_timeout", n), 64'(p.timeout), 0);
      chk($sformatf("rnd_p%0d_seq", n), 64'(p.seq), 64'(n));
      chk($sformatf("rnd_p%0d_stable", n), 64'(p.stable_ok), 1);
      chk($sformatf("rnd_p%0d_payload", n), 64'(p.data_ok & p.keep_ok), 1);
      chk($sformatf("rnd_p%0d_shape", n), {p.last_keep, 32'(p.beats)}, {32'h3F, 32'd3});
    end
    cfg_enable = 1'b0;
    tick(); tick();
    chk("rnd_scoreboard_beats", 64'(acc_beats), 30);
    chk("rnd_frame_count", 64'(sent_frame_count), 64'(acc_beats));
    chk("rnd_pk_count", 64'(sent_pk_count), 10);

    // Reset on beat 1 of a 3-beat packet
    cfg_class_mask = 5'b00001;
    cfg_pk_len = 16'd70;
    cfg_enable = 1'b1;
    lat = 0;
    while (!m_axis_tvalid && lat < 20) begin tick(); lat++; end
    chk("mrst_start", 64'(lat), 2);
    tick();
    chk("mrst_on_beat1", {63'd0, m_axis_tvalid & ~m_axis_tlast}, 1);
    rst_n = 1'b0;
    cfg_class_mask = 5'b11111;
    tick();
    chk("mrst_tvalid", 64'(m_axis_tvalid), 0);
    chk("mrst_frcnt", 64'(sent_frame_count), 0);
    chk("mrst_pkcnt", 64'(sent_pk_count), 0);
    rst_n = 1'b1;
    get_pkt(0, p);
    cfg_enable = 1'b0;
    chk("mrst_timeout", 64'(p.timeout), 0);
    chk("mrst_class", 64'(p.cls), 0);
    chk("mrst_seq", 64'(p.seq), 0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
